// File: rtl/match_event_logger_pkg.sv
// Shared types and default sizing for the match event logger.
package match_log_pkg;

  localparam int TS_W_DEF    = 16;
  localparam int DEPTH_DEF   = 4;
  localparam int CNT_W_DEF   = 8;
  localparam int HOLDOFF_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } holdoff_state_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/match_event_logger_if.sv
// Read-side handshake of the timestamp FIFO (valid/ready, FWFT data, occupancy).
interface match_log_rd_if #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4
);
  logic                   rd_valid;
  logic                   rd_ready;
  logic [TS_W-1:0]        rd_data;
  logic [$clog2(DEPTH):0] level;

  modport master (output rd_valid, output rd_data, output level, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input level, output rd_ready);
endinterface

// File: rtl/match_event_logger_fifo.sv
// Synchronous first-word-fall-through FIFO holding match timestamps.
module match_ts_fifo
  import match_log_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic                   full,
  output logic                   empty,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;
  occ_state_t   occ;

  // Extra top pointer bit separates full (wrap bits differ) from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_comb begin
    occ = EMPTY;
    if (full)        occ = FULL;
    else if (!empty) occ = PARTIAL;
  end

  a_pop_not_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));
  a_full_level:    assert property (@(posedge clk) disable iff (reset)
                                    (occ == FULL) |-> (level == (AW+1)'(DEPTH)));
  a_level_bound:   assert property (@(posedge clk) disable iff (reset)
                                    level <= (AW+1)'(DEPTH));

endmodule

// File: rtl/match_event_logger.sv
// Timestamps detector match pulses into a FIFO; keeps a saturating count and sticky overflow.
// Optional holdoff after each accepted match: define MATCH_LOG_HOLDOFF_EN.
//   state | meaning
//   IDLE  | matches accepted
//   HOLD  | matches ignored while the holdoff down-counter runs to 1
module match_event_logger
  import match_log_pkg::*;
#(
  parameter int TS_W    = TS_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_match,
  input  logic             clear,
  match_log_rd_if.master   rd,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow
);

  logic [TS_W-1:0] ts;
  logic            allow;
  logic            accept;
  logic            pop;
  logic            drop;
  logic            fifo_full;
  logic            fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

`ifdef MATCH_LOG_HOLDOFF_EN
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  holdoff_state_t state;
  holdoff_state_t state_nxt;
  logic [HW-1:0]  hcnt;
  logic [HW-1:0]  hcnt_nxt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= IDLE;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    allow     = 1'b0;
    case (state)
      IDLE: begin
        allow = 1'b1;
        if (in_match && (HOLDOFF != 0)) begin
          state_nxt = HOLD;
          hcnt_nxt  = HW'(HOLDOFF);
        end
      end
      HOLD: begin
        hcnt_nxt = hcnt - HW'(1);
        if (hcnt == HW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  logic unused_holdoff;
  assign unused_holdoff = ^HOLDOFF;
  assign allow          = 1'b1;
`endif

  assign accept      = in_match && allow;
  assign pop         = rd.rd_valid && rd.rd_ready;
  assign drop        = accept && fifo_full && !pop;
  assign rd.rd_valid = !fifo_empty;

  match_ts_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (accept),
    .pop   (pop),
    .din   (ts),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (rd.rd_data),
    .level (rd.level)
  );

  // Dropped matches still count; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      match_count <= '0;
    end else if (accept && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
  end

endmodule

// File: tb/tb_match_event_logger.sv
// Directed bench for match_event_logger: three instances share stimulus (base, 4-bit ts, holdoff=3).
module tb_match_event_logger;

  logic clk = 1'b0;
  logic reset;
  logic in_match;
  logic clear;
  logic rd_ready;

  int tsm;
  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] cnt_a, cnt_w, cnt_h;
  logic       ovf_a, ovf_w, ovf_h;

  match_log_rd_if #(.TS_W(16), .DEPTH(4)) rd_a ();
  match_log_rd_if #(.TS_W(4),  .DEPTH(4)) rd_w ();
  match_log_rd_if #(.TS_W(16), .DEPTH(4)) rd_h ();

  assign rd_a.rd_ready = rd_ready;
  assign rd_w.rd_ready = rd_ready;
  assign rd_h.rd_ready = rd_ready;

  match_event_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8), .HOLDOFF(0)) dut_a (
    .clk(clk), .reset(reset), .in_match(in_match), .clear(clear),
    .rd(rd_a), .match_count(cnt_a), .overflow(ovf_a));

  match_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(8), .HOLDOFF(0)) dut_w (
    .clk(clk), .reset(reset), .in_match(in_match), .clear(clear),
    .rd(rd_w), .match_count(cnt_w), .overflow(ovf_w));

  match_event_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8), .HOLDOFF(3)) dut_h (
    .clk(clk), .reset(reset), .in_match(in_match), .clear(clear),
    .rd(rd_h), .match_count(cnt_h), .overflow(ovf_h));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    tsm++;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_match = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    tsm = 0;
  endtask

  task automatic goto_ts(input int t);
    while (tsm < t) step();
  endtask

  int exp_q[$];

  initial begin
    reset = 1'b1; in_match = 1'b0; clear = 1'b0; rd_ready = 1'b0; tsm = 0;
    @(negedge clk);

    // 1: reset state, single pulse at ts=5
    do_reset();
    chk("rst_valid", 32'(rd_a.rd_valid), 0);
    chk("rst_level", 32'(rd_a.level), 0);
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_ovf",   32'(ovf_a), 0);
    goto_ts(5);
    in_match = 1'b1; step(); in_match = 1'b0;
    chk("t1_valid", 32'(rd_a.rd_valid), 1);
    chk("t1_data",  32'(rd_a.rd_data), 5);
    chk("t1_level", 32'(rd_a.level), 1);
    chk("t1_count", 32'(cnt_a), 1);

    // 2: five pulses into depth 4, then drain
    do_reset();
    goto_ts(10);
    in_match = 1'b1;
    repeat (5) step();
    in_match = 1'b0;
    chk("t2_level", 32'(rd_a.level), 4);
    chk("t2_ovf",   32'(ovf_a), 1);
    chk("t2_count", 32'(cnt_a), 5);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_dvalid", 32'(rd_a.rd_valid), 1);
      chk("t2_drain",  32'(rd_a.rd_data), 32'(10 + i));
      step();
    end
    rd_ready = 1'b0;
    chk("t2_empty", 32'(rd_a.rd_valid), 0);
    chk("t2_lvl0",  32'(rd_a.level), 0);

    // 3: push and pop together while full
    do_reset();
    goto_ts(1);
    in_match = 1'b1;
    repeat (4) step();
    chk("t3_full", 32'(rd_a.level), 4);
    rd_ready = 1'b1;
    step();
    in_match = 1'b0; rd_ready = 1'b0;
    chk("t3_level", 32'(rd_a.level), 4);
    chk("t3_ovf",   32'(ovf_a), 0);
    chk("t3_count", 32'(cnt_a), 5);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", 32'(rd_a.rd_data), 32'(2 + i));
      step();
    end
    rd_ready = 1'b0;
    chk("t3_empty", 32'(rd_a.rd_valid), 0);

    // 4: counter saturation, then clear beats a simultaneous pulse
    do_reset();
    in_match = 1'b1;
    repeat (254) step();
    chk("t4_cnt254", 32'(cnt_a), 254);
    repeat (46) step();
    chk("t4_sat",   32'(cnt_a), 255);
    chk("t4_ovf1",  32'(ovf_a), 1);
    chk("t4_full",  32'(rd_a.level), 4);
    clear = 1'b1;
    step();
    clear = 1'b0; in_match = 1'b0;
    chk("t4_clr_cnt",   32'(cnt_a), 0);
    chk("t4_clr_level", 32'(rd_a.level), 0);
    chk("t4_clr_ovf",   32'(ovf_a), 0);
    chk("t4_clr_valid", 32'(rd_a.rd_valid), 0);
    step();
    chk("t4_nolog", 32'(rd_a.level), 0);

    // 5: 4-bit timestamp wrap
    do_reset();
    goto_ts(15);
    in_match = 1'b1; step(); in_match = 1'b0;
    step();
    in_match = 1'b1; step(); in_match = 1'b0;
    chk("t5_level", 32'(rd_w.level), 2);
    chk("t5_d0",    32'(rd_w.rd_data), 15);
    rd_ready = 1'b1;
    step();
    chk("t5_valid", 32'(rd_w.rd_valid), 1);
    chk("t5_d1",    32'(rd_w.rd_data), 1);
    step();
    rd_ready = 1'b0;
    chk("t5_empty", 32'(rd_w.rd_valid), 0);

    // 6: pulse every cycle for 6 cycles from ts=20
    do_reset();
    goto_ts(20);
    in_match = 1'b1;
    repeat (6) step();
    in_match = 1'b0;
    chk("t6_a_count", 32'(cnt_a), 6);
    chk("t6_a_ovf",   32'(ovf_a), 1);
`ifdef MATCH_LOG_HOLDOFF_EN
    chk("t6_h_count", 32'(cnt_h), 2);
    chk("t6_h_ovf",   32'(ovf_h), 0);
    chk("t6_h_level", 32'(rd_h.level), 2);
    exp_q = '{20, 24};
`else
    chk("t6_h_count", 32'(cnt_h), 6);
    chk("t6_h_ovf",   32'(ovf_h), 1);
    chk("t6_h_level", 32'(rd_h.level), 4);
    exp_q = '{20, 21, 22, 23};
`endif
    rd_ready = 1'b1;
    foreach (exp_q[i]) begin
      chk("t6_h_valid", 32'(rd_h.rd_valid), 1);
      chk("t6_h_drain", 32'(rd_h.rd_data), 32'(exp_q[i]));
      step();
    end
    rd_ready = 1'b0;
    chk("t6_h_empty", 32'(rd_h.rd_valid), 0);

    // Reset mid-operation discards an in-flight pulse
    in_match = 1'b1; step();
    chk("rst_mid_pre", 32'(rd_a.level), 1);
    reset = 1'b1; step();
    reset = 1'b0; in_match = 1'b0;
    chk("rst_mid_level", 32'(rd_a.level), 0);
    chk("rst_mid_count", 32'(cnt_a), 0);
    chk("rst_mid_valid", 32'(rd_a.rd_valid), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
